// File: rtl/hamming_decoder_if.sv
// Handshake and status bundle for the Hamming(12,8) receive decoder.
// The master side feeds codewords and consumes results; the slave side is the decoder.
interface hamming_decoder_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [11:0]          hc_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           data_out;
    logic [3:0]           syndrome;
    logic                 err_corr;
    logic                 err_uncorr;
    logic                 cnt_clr;
    logic [CNT_WIDTH-1:0] corr_cnt;
    logic [CNT_WIDTH-1:0] uncorr_cnt;

    modport master (
        output in_valid, hc_in, out_ready, cnt_clr,
        input  in_ready, out_valid, data_out, syndrome, err_corr, err_uncorr,
               corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, hc_in, out_ready, cnt_clr,
        output in_ready, out_valid, data_out, syndrome, err_corr, err_uncorr,
               corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamming_decoder.sv
// Hamming(12,8) decoder: 2-stage valid/ready pipeline, single-error correction.
// Define HAMMING_DEC_STATS_EN to build the saturating corrected/uncorrectable counters.
module hamming_decoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hamming_decoder_if.slave bus
);
    logic        s1_valid;
    logic [11:0] s1_code;
    logic [3:0]  s1_syn;
    logic        s1_ready;
    logic        s2_ready;
    logic [3:0]  syn_in;
    logic [11:0] flip_mask;
    logic [11:0] fixed_code;

    logic        out_valid_q;
    logic [7:0]  data_q;
    logic [3:0]  syn_q;
    logic        corr_q;
    logic        uncorr_q;

    // Each syndrome bit is the parity of the positions whose index has that bit set.
    always_comb begin
        syn_in[0] = ^{bus.hc_in[0], bus.hc_in[2], bus.hc_in[4], bus.hc_in[6], bus.hc_in[8], bus.hc_in[10]};
        syn_in[1] = ^{bus.hc_in[1], bus.hc_in[2], bus.hc_in[5], bus.hc_in[6], bus.hc_in[9], bus.hc_in[10]};
        syn_in[2] = ^{bus.hc_in[3], bus.hc_in[4], bus.hc_in[5], bus.hc_in[6], bus.hc_in[11]};
        syn_in[3] = ^{bus.hc_in[7], bus.hc_in[8], bus.hc_in[9], bus.hc_in[10], bus.hc_in[11]};
    end

    assign s2_ready     = ~out_valid_q | bus.out_ready;
    assign s1_ready     = ~s1_valid | s2_ready;
    assign bus.in_ready = s1_ready;

    // NOTE: the default assignment before the loop keeps this block free of inferred latches.
    always_comb begin
        flip_mask = '0;
        for (int k = 0; k < 12; k++) begin
            flip_mask[k] = (s1_syn == 4'(k + 1));
        end
    end

    assign fixed_code = s1_code ^ flip_mask;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_code <= bus.hc_in;
                s1_syn  <= syn_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            syn_q       <= '0;
            corr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                data_q   <= {fixed_code[11:8], fixed_code[6:4], fixed_code[2]};
                syn_q    <= s1_syn;
                corr_q   <= (s1_syn != 4'd0) && (s1_syn <= 4'd12);
                uncorr_q <= (s1_syn >= 4'd13);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.syndrome   = syn_q;
    assign bus.err_corr   = corr_q;
    assign bus.err_uncorr = uncorr_q;

`ifdef HAMMING_DEC_STATS_EN
    logic                 out_fire;
    logic [CNT_WIDTH-1:0] corr_cnt_q;
    logic [CNT_WIDTH-1:0] uncorr_cnt_q;

    assign out_fire = out_valid_q & bus.out_ready;

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (out_fire) begin
            if (corr_q && (corr_cnt_q != '1))
                corr_cnt_q <= corr_cnt_q + CNT_WIDTH'(1);
            if (uncorr_q && (uncorr_cnt_q != '1))
                uncorr_cnt_q <= uncorr_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.corr_cnt   = corr_cnt_q;
    assign bus.uncorr_cnt = uncorr_cnt_q;
`else
    assign bus.corr_cnt   = '0;
    assign bus.uncorr_cnt = '0;
`endif
endmodule
